video_syncs: RTL and testbench
==============================

# video_syncs

Raster timing generator for the video path: counts 7 MHz pixel slots (`cend` strobes) into lines and frames. Produces the line/frame markers that drive the fetch stage: `line_start`, `vpix`, `int_start`. Also produces the pixel window, blanking, sync and Z80 INT signals used by the output mixer and the CPU glue. All outputs are registered, with one clock domain.

## Interface
Parameters (counts are in `cend` units horizontally and lines vertically):
- `H_TOTAL`, 448: pixel slots per line.
- `V_TOTAL`, 320: lines per frame.
- `HPIX_BEG`, 52: first hcount of the 256-slot pixel window.
- `VPIX_BEG`, 64: first line of the 192-line pixel window.
- `HBLNK_BEG`, 384: hblank spans hcount HBLNK_BEG..H_TOTAL-1.
- `HSYNC_BEG`, 400; `HSYNC_LEN`, 34: horizontal sync position and length.
- `VBLNK_BEG`, 304: vblank spans lines VBLNK_BEG..V_TOTAL-1.
- `VSYNC_BEG`, 308; `VSYNC_LEN`, 4: vertical sync position and length.
- `INT_HPOS`, 2: hcount of `int_start` on line 0.
- `INT_LEN`, 32: `int_n` low duration in `cend` slots.

Ports:
- `clk` (in, 1): system clock.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `cend` (in, 1): one-clk strobe marking each pixel slot; all counting advances only on `cend`.
- `line_start` (out, 1): one-clk pulse on the `cend` clock where hcount wraps to 0.
- `int_start` (out, 1): one-clk pulse on the `cend` clock where line 0, hcount INT_HPOS is entered.
- `int_n` (out, 1): Z80 INT, active low.
- `vpix` (out, 1): current line is inside the 192-line window.
- `hpix` (out, 1): current slot is inside the 256-slot window.
- `border` (out, 1): visible, but not pixel.
- `hblank`, `vblank` (out, 1): blanking.
- `hsync_n`, `vsync_n`, `csync_n` (out, 1): syncs, active low; `csync_n` = `hsync_n & vsync_n`.

## Operation
- hcount runs 0..H_TOTAL-1 and increments on `cend`. On wrap it returns to 0 and vcount increments.
- vcount runs 0..V_TOTAL-1 and wraps to 0.
- Counter widths: 9 bits each; wrap is by compare, not by overflow.
- Window and blank terms are evaluated on the next-state counter values and registered. Each output therefore reflects the slot or line being entered on the same clock edge.
- `vpix` = vcount in [VPIX_BEG, VPIX_BEG+191].
  - It is already valid on the `line_start` clock of its line.
  - Fetch samples `line_start && vpix` in the same clock, so it must see exactly 192 such coincidences per frame.
- `hpix` = hcount in [HPIX_BEG, HPIX_BEG+255].
- `border` = !(hpix && vpix) && !hblank && !vblank.
- `hsync_n` is low for hcount in [HSYNC_BEG, HSYNC_BEG+HSYNC_LEN-1].
- `vsync_n` is low for vcount in [VSYNC_BEG, VSYNC_BEG+VSYNC_LEN-1].
- INT generation:
  - `int_start` also loads a 6-bit INT counter with INT_LEN and drives `int_n` low.
  - The counter decrements on `cend`.
  - `int_n` returns high on the `cend` where the counter reaches 0, i.e. exactly INT_LEN slots low.
- `int_start` never coincides with a `vpix` `line_start`: line 0 lies outside the window.

## Timing
- Reset values:
  - hcount = 0, vcount = 0, INT counter = 0.
  - `line_start` = 0, `int_start` = 0, `int_n` = 1.
  - `vpix`, `hpix`, `border`, `hblank`, `vblank` = 0.
  - `hsync_n`, `vsync_n`, `csync_n` = 1.
- After `rst_n` rises, the first `cend` moves to hcount 1.
  - The first `line_start` comes H_TOTAL-1 `cend` strobes later.
  - The first `int_start` comes at line 0 of the next frame.
- Pulses are exactly one `clk` wide and coincide with a `cend` clock. Between `cend` strobes all outputs hold.
- Latency: 0 clocks from the counter state to its decoded output (registered next-state decode).
- Asserting `rst_n` mid-frame asynchronously forces all reset values. An INT in progress is aborted with `int_n` = 1.
- Line rate is 448 `cend` = 64 µs at 7 MHz; frame is 143360 `cend`.

## Structure
- Default timing constants go in the shared video timing include next to `tune.v`. The constants are H_TOTAL, V_TOTAL, the window origins, and the fixed 256/192 window sizes.
- Fetch uses the same include for its fetch lead (HPIX_BEG minus 16).
- No sub-module.

## Test plan
- **Reset:** hold `rst_n` = 0, toggle `cend` → all outputs at their reset values. Release and apply 447 `cend` strobes → `line_start` pulses once on the 448th.
- **Frame count:** run one full frame with `cend` every 2 clocks → 320 `line_start`, 192 `line_start && vpix`, 1 `int_start`, 4 lines with `vsync_n` = 0.
- **Pixel window:** on line 64, `hpix` rises on the `cend` entering hcount 52 and falls entering hcount 308. Per frame, `hpix && vpix` is high for 49152 `cend` strobes.
- **INT:** `int_start` occurs at line 0, hcount 2 → `int_n` is low for exactly 32 `cend` strobes and high afterwards.
- **Syncs:** `hsync_n` is low for hcount 400..433. `csync_n` is low in the vsync lines and during hsync, and high otherwise.
- **Async reset:** assert `rst_n` at line 150, hcount 200, with `int_n` low by forcing the position → immediate reset values without waiting for `clk`. Timing restarts from hcount 0.

Source files
------------

// File: rtl/video_syncs_pkg.sv
// Shared raster timing defaults for the video path (sync generator and fetch).
// Pure constants and decode helpers; no state, no latency, no flow control.
package video_syncs_pkg;

  localparam int H_TOTAL_DEF   = 448;
  localparam int V_TOTAL_DEF   = 320;
  localparam int HPIX_BEG_DEF  = 52;
  localparam int VPIX_BEG_DEF  = 64;
  localparam int HPIX_LEN_DEF  = 256;
  localparam int VPIX_LEN_DEF  = 192;
  // Fetch runs ahead of the pixel window by this many slots.
  localparam int FETCH_LEAD    = 16;
  localparam int FETCH_BEG_DEF = HPIX_BEG_DEF - FETCH_LEAD;

  localparam int CNT_W     = 9;
  localparam int INT_CNT_W = 6;

  function automatic logic in_win(input logic [CNT_W-1:0] c, input int beg, input int len);
    return (int'(c) >= beg) && (int'(c) < beg + len);
  endfunction

endpackage

// File: rtl/video_syncs.sv
// Raster timing generator: counts cend slots into lines/frames, decodes windows, syncs, INT.
// Outputs registered from next-state counters (0 clk decode latency); advances only on cend, no backpressure.
module video_syncs
  import video_syncs_pkg::*;
#(
  parameter int H_TOTAL   = H_TOTAL_DEF,
  parameter int V_TOTAL   = V_TOTAL_DEF,
  parameter int HPIX_BEG  = HPIX_BEG_DEF,
  parameter int VPIX_BEG  = VPIX_BEG_DEF,
  parameter int HPIX_LEN  = HPIX_LEN_DEF,
  parameter int VPIX_LEN  = VPIX_LEN_DEF,
  parameter int HBLNK_BEG = 384,
  parameter int HSYNC_BEG = 400,
  parameter int HSYNC_LEN = 34,
  parameter int VBLNK_BEG = 304,
  parameter int VSYNC_BEG = 308,
  parameter int VSYNC_LEN = 4,
  parameter int INT_HPOS  = 2,
  parameter int INT_LEN   = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cend,
  output logic line_start,
  output logic int_start,
  output logic int_n,
  output logic vpix,
  output logic hpix,
  output logic border,
  output logic hblank,
  output logic vblank,
  output logic hsync_n,
  output logic vsync_n,
  output logic csync_n
);

  localparam logic [CNT_W-1:0]     H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]     V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]     INT_H   = CNT_W'(INT_HPOS);
  localparam logic [INT_CNT_W-1:0] INT_LD  = INT_CNT_W'(INT_LEN);

  logic [CNT_W-1:0]     hcount, vcount, h_nxt, v_nxt;
  logic [INT_CNT_W-1:0] int_cnt;
  logic                 int_armed;
  logic                 h_wrap, frame_wrap, int_fire;
  logic                 hpix_nxt, vpix_nxt, hblank_nxt, vblank_nxt, hsync_n_nxt, vsync_n_nxt;

  always_comb begin
    h_wrap      = (hcount == H_LAST);
    frame_wrap  = h_wrap && (vcount == V_LAST);
    h_nxt       = h_wrap ? '0 : hcount + 1'b1;
    v_nxt       = vcount;
    if (h_wrap) v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    // The frame following reset is partial, so INT waits for the first full frame.
    int_fire    = (int_armed || frame_wrap) && (v_nxt == '0) && (h_nxt == INT_H);
    hpix_nxt    = in_win(h_nxt, HPIX_BEG, HPIX_LEN);
    vpix_nxt    = in_win(v_nxt, VPIX_BEG, VPIX_LEN);
    hblank_nxt  = in_win(h_nxt, HBLNK_BEG, H_TOTAL - HBLNK_BEG);
    vblank_nxt  = in_win(v_nxt, VBLNK_BEG, V_TOTAL - VBLNK_BEG);
    hsync_n_nxt = !in_win(h_nxt, HSYNC_BEG, HSYNC_LEN);
    vsync_n_nxt = !in_win(v_nxt, VSYNC_BEG, VSYNC_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount     <= '0;
      vcount     <= '0;
      int_cnt    <= '0;
      int_armed  <= 1'b0;
      line_start <= 1'b0;
      int_start  <= 1'b0;
      int_n      <= 1'b1;
      vpix       <= 1'b0;
      hpix       <= 1'b0;
      border     <= 1'b0;
      hblank     <= 1'b0;
      vblank     <= 1'b0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      csync_n    <= 1'b1;
    end else if (cend) begin
      hcount     <= h_nxt;
      vcount     <= v_nxt;
      line_start <= h_wrap;
      int_start  <= int_fire;
      if (frame_wrap) int_armed <= 1'b1;
      vpix       <= vpix_nxt;
      hpix       <= hpix_nxt;
      hblank     <= hblank_nxt;
      vblank     <= vblank_nxt;
      border     <= !(hpix_nxt && vpix_nxt) && !hblank_nxt && !vblank_nxt;
      hsync_n    <= hsync_n_nxt;
      vsync_n    <= vsync_n_nxt;
      csync_n    <= hsync_n_nxt && vsync_n_nxt;
      if (int_fire) begin
        int_cnt <= INT_LD;
        int_n   <= 1'b0;
      end else if (int_cnt != '0) begin
        int_cnt <= int_cnt - 1'b1;
        if (int_cnt == INT_CNT_W'(1)) int_n <= 1'b1;
      end
    end else begin
      line_start <= 1'b0;
      int_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_syncs.sv
// Randomized scoreboard bench for video_syncs on a reduced raster geometry.
module tb_video_syncs;

  localparam int H   = 48;
  localparam int V   = 30;
  localparam int HPB = 6;
  localparam int HPL = 24;
  localparam int VPB = 5;
  localparam int VPL = 18;
  localparam int HBB = 36;
  localparam int HSB = 38;
  localparam int HSL = 5;
  localparam int VBB = 25;
  localparam int VSB = 26;
  localparam int VSL = 2;
  localparam int IHP = 2;
  localparam int ILN = 10;
  localparam int F   = H * V;

  typedef struct packed {
    logic line_start, int_start, int_n, vpix, hpix, border, hblank, vblank, hsync_n, vsync_n, csync_n;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cend = 1'b0;
  logic line_start, int_start, int_n, vpix, hpix, border, hblank, vblank, hsync_n, vsync_n, csync_n;
  obs_t act;

  video_syncs #(
    .H_TOTAL(H), .V_TOTAL(V), .HPIX_BEG(HPB), .VPIX_BEG(VPB), .HPIX_LEN(HPL), .VPIX_LEN(VPL),
    .HBLNK_BEG(HBB), .HSYNC_BEG(HSB), .HSYNC_LEN(HSL), .VBLNK_BEG(VBB), .VSYNC_BEG(VSB),
    .VSYNC_LEN(VSL), .INT_HPOS(IHP), .INT_LEN(ILN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cend(cend), .line_start(line_start), .int_start(int_start),
    .int_n(int_n), .vpix(vpix), .hpix(hpix), .border(border), .hblank(hblank), .vblank(vblank),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n)
  );

  assign act = {line_start, int_start, int_n, vpix, hpix, border, hblank, vblank, hsync_n, vsync_n, csync_n};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];
  bit   cend_q[$];

  // Reference model: absolute slot position within the frame since reset.
  int   pos, frames_seen, int_age;
  bit   int_active;
  obs_t last;

  bit tally_en = 0;
  int t_ls = 0, t_lsv = 0, t_int = 0, t_vs = 0, t_pix = 0;

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.int_n = 1'b1; o.hsync_n = 1'b1; o.vsync_n = 1'b1; o.csync_n = 1'b1;
    return o;
  endfunction

  task automatic model_reset();
    pos = 0; frames_seen = 0; int_age = 0; int_active = 0; last = rst_obs();
  endtask

  task automatic model_step(input bit c);
    obs_t e;
    int h, v;
    e = last;
    e.line_start = 1'b0;
    e.int_start  = 1'b0;
    if (c) begin
      pos = (pos + 1) % F;
      if (pos == 0) frames_seen++;
      h = pos % H;
      v = pos / H;
      if (int_active) begin
        int_age++;
        if (int_age >= ILN) int_active = 0;
      end
      e.line_start = (h == 0);
      e.int_start  = (frames_seen > 0) && (v == 0) && (h == IHP);
      if (e.int_start) begin
        int_active = 1; int_age = 0;
      end
      e.int_n   = !int_active;
      e.hpix    = (h >= HPB) && (h < HPB + HPL);
      e.vpix    = (v >= VPB) && (v < VPB + VPL);
      e.hblank  = (h >= HBB);
      e.vblank  = (v >= VBB);
      e.border  = !(e.hpix && e.vpix) && !e.hblank && !e.vblank;
      e.hsync_n = !((h >= HSB) && (h < HSB + HSL));
      e.vsync_n = !((v >= VSB) && (v < VSB + VSL));
      e.csync_n = e.hsync_n && e.vsync_n;
    end
    last = e;
    exp_q.push_back(e);
    cend_q.push_back(c);
  endtask

  task automatic check_obs(input string name, input obs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, e);
    end
  endtask

  task automatic check_int(input string name, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, e);
    end
  endtask

  task automatic tick(input bit c);
    @(negedge clk);
    cend = c;
    model_step(c);
  endtask

  // Monitor: pops one expected observation per clock after the edge it predicts.
  initial begin
    obs_t e;
    bit   c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cend_q.pop_front();
        check_obs("cycle", e);
        if (tally_en) begin
          if (line_start) t_ls++;
          if (line_start && vpix) t_lsv++;
          if (int_start) t_int++;
          if (line_start && !vsync_n) t_vs++;
          if (c && hpix && vpix) t_pix++;
        end
      end
    end
  end

  initial begin
    int n, guard;
    bit found;
    model_reset();

    // Reset hold with cend toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_obs("reset_hold", rst_obs());
      cend = ~cend;
    end
    @(negedge clk);
    cend = 1'b0;
    rst_n = 1'b1;
    model_reset();
    tally_en = 1;

    // Two frames with cend every other clock.
    for (int i = 0; i < 2 * F; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
    @(posedge clk);
    #2;
    tally_en = 0;
    check_int("line_start_count", t_ls, 2 * V);
    check_int("vpix_line_count", t_lsv, 2 * VPL);
    check_int("int_start_count", t_int, 1);
    check_int("vsync_line_count", t_vs, 2 * VSL);
    check_int("pixel_slot_count", t_pix, 2 * HPL * VPL);

    // Random cend density, then stop mid-INT.
    n = 0; guard = 0; found = 0;
    while (!found && guard < 20000) begin
      tick($urandom_range(0, 2) == 0);
      if (last.line_start || cend) n += cend;
      guard++;
      found = (n >= F) && int_active && (int_age == 3);
    end
    if (!found) begin
      errors++;
      $display("FAIL int_window_timeout: got no INT in %0d clocks required one", guard);
    end
    check_int("int_low_before_reset", int'(int_n), 0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    cend = 1'b0;
    rst_n = 1'b0;
    #1;
    check_obs("async_reset", rst_obs());
    @(negedge clk);
    check_obs("async_reset_hold", rst_obs());
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < F + 200; i++) tick($urandom_range(0, 1) == 1);
    tick(1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check_int("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
